// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Run-control sequencer for the 9-bit single-cycle processor. Walks
// IDLE -> CLEAR -> HOLD -> RUN -> DONE. Before every run it zeroes data memory
// and holds the PC and register file in clear. During the run it gates
// commits, counts RUN cycles and raises done when the decoder reports a halt.
//
// Optional feature macro: RUN_WATCHDOG_EN. When it is defined, a run that
// reaches WDOG_LIMIT cycles without a halt ends with timeout=1. When it is
// undefined, timeout stays 0 and WDOG_LIMIT has no effect.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous active-low reset
//   start        run request, level-sampled
//   halt         decoder halt indication, sampled only in RUN
//   run_en       PC update / register and memory commit enable
//   clear_en     synchronous clear to the PC and register file
//   clr_we       data memory write strobe for the zero sweep
//   clr_addr     data memory sweep address
//   done         program finished
//   cycle_count  RUN cycles in the last or current run (saturating)
//   timeout      run ended by the watchdog rather than by halt
module cpu_run_controller #(
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WDOG_LIMIT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic              run_en,
  output logic              clear_en,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              timeout
);

`ifdef RUN_WATCHDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  // Watchdog path stays in the source but is constant-disabled.
  localparam bit WdogEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DMEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};
  localparam logic [31:0]       WdogLimit32 = 32'(WDOG_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StHold,
    StRun,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                timeout_q, timeout_d;
  logic                run_en_q, clear_en_q, clr_we_q, done_q;

  logic [CNT_W-1:0]    count_inc;
  logic                wdog_hit;
  logic                enter_clear;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign count_inc = (cycle_count_q == CntMax) ? cycle_count_q : cycle_count_q + CNT_W'(1);
  assign wdog_hit  = (32'(count_inc) == WdogLimit32);

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    enter_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StClear;
          enter_clear = 1'b1;
        end
      end
      StClear: begin
        if (clr_addr_q == LastAddr) begin
          state_d    = StHold;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      StHold: begin
        if (!start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // The halt cycle is counted; halt beats a simultaneous watchdog hit.
        cycle_count_d = count_inc;
        if (halt) begin
          state_d = StDone;
        end else if (WdogEn && wdog_hit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StDone: begin
        if (start) begin
          state_d     = StClear;
          enter_clear = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (enter_clear) begin
      clr_addr_d    = '0;
      cycle_count_d = '0;
      timeout_d     = 1'b0;
    end
  end

  // Outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      clr_addr_q    <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      run_en_q      <= 1'b0;
      clear_en_q    <= 1'b0;
      clr_we_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      run_en_q      <= (state_d == StRun);
      clear_en_q    <= (state_d == StClear) || (state_d == StHold);
      clr_we_q      <= (state_d == StClear);
      done_q        <= (state_d == StDone);
    end
  end

  assign run_en      = run_en_q;
  assign clear_en    = clear_en_q;
  assign clr_we      = clr_we_q;
  assign clr_addr    = clr_addr_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run-control sequencer for the 9-bit single-cycle processor. It replaces the free-running start/done handling in the top level with an explicit IDLE/CLEAR/HOLD/RUN/DONE state machine. It clears data memory and architectural state before every run, gates PC and register/memory commits, counts executed cycles, and raises `done` when the decoder reports a halt. It sits between the testbench `start`/`done` pins and the program counter, register file and data memory write ports.

## Interface
Parameters:
- `DMEM_DEPTH`, 256: data memory words swept during CLEAR.
- `ADDR_W`, 8: width of `clr_addr`; must satisfy 2^ADDR_W >= DMEM_DEPTH.
- `CNT_W`, 16: width of `cycle_count`.
- `WDOG_LIMIT`, 4096: RUN-cycle limit. Used only when `RUN_WATCHDOG_EN` is defined.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 means in reset.
- `start`  in  1  run request from the testbench; level-sampled.
- `halt`  in  1  decoder's halt-instruction indication; sampled only in RUN.
- `run_en`  out  1  enables PC update and register/memory commits.
- `clear_en`  out  1  synchronous clear to the PC (PC forced to 0) and to the register file.
- `clr_we`  out  1  data memory write strobe for the zero sweep.
- `clr_addr`  out  ADDR_W  data memory sweep address.
- `done`  out  1  program finished.
- `cycle_count`  out  CNT_W  number of RUN cycles in the last or current run.
- `timeout`  out  1  the run ended by watchdog rather than by halt.

## Operation
States: IDLE, CLEAR, HOLD, RUN, DONE. All outputs are Moore outputs decoded from registered state and counters.

- **Reset** (`reset`=0, asynchronous): state=IDLE, `clr_addr`=0, `cycle_count`=0.
  - `run_en`=0, `clear_en`=0, `clr_we`=0, `done`=0, `timeout`=0.
- **IDLE**: `start`=1 → CLEAR. Otherwise stay.
- **CLEAR**:
  - Outputs: `clear_en`=1, `clr_we`=1, `clr_addr` steps 0,1,…,DMEM_DEPTH-1, one word per cycle.
  - On the cycle with `clr_addr`=DMEM_DEPTH-1 → HOLD; `clr_addr` returns to 0.
  - `start` is ignored during CLEAR.
- **HOLD**: `clear_en`=1. `start`=1 → stay. `start`=0 → RUN.
- **RUN**:
  - `run_en`=1; `cycle_count` increments every RUN cycle, saturating at 2^CNT_W-1 (no wrap).
  - `halt`=1 → DONE. The halt cycle itself is counted, and the halt instruction commits as a no-op.
  - `start` is ignored in RUN.
- **DONE**:
  - `done`=1; `cycle_count` and `timeout` are held.
  - `start`=1 → CLEAR; `done` drops on that transition.
- **Entry into CLEAR** (from IDLE or DONE): `cycle_count`←0 and `timeout`←0.
- **Simultaneous events**: in RUN, a halt on the same cycle the watchdog limit is reached → DONE with `timeout`=0 (halt wins).
- **Reset mid-operation**: any state → IDLE immediately. No partial sweep is resumed.

## Timing
- Start sampled 1 in IDLE at edge N → `clr_we`=1, `clr_addr`=0 after edge N.
- Last sweep write: cycle N+DMEM_DEPTH. HOLD begins after edge N+DMEM_DEPTH.
- `start` sampled 0 in HOLD at edge M → `run_en`=1 after edge M.
- Earliest RUN is DMEM_DEPTH+1 edges after start is sampled.
- Halt sampled at edge H → `done`=1 and `run_en`=0 after edge H. One cycle of latency.
- `clear_en` stays high through CLEAR and HOLD. The first RUN cycle therefore fetches from PC=0.

## Configuration
- `RUN_WATCHDOG_EN` defined:
  - In RUN, when `cycle_count` reaches `WDOG_LIMIT` without a halt → DONE with `timeout`=1 on the next cycle.
  - `cycle_count` reads exactly `WDOG_LIMIT` in that case.
- `RUN_WATCHDOG_EN` undefined:
  - No limit; RUN persists until halt or reset.
  - `timeout` tied to 0; `WDOG_LIMIT` unused.

## Test plan
- **Reset values**: reset low mid-RUN → next sample shows IDLE, all outputs 0, `cycle_count`=0.
- **Clear sweep**: DMEM_DEPTH=8; start=1 for 20 cycles → `clr_addr` 0..7 with `clr_we`=1 for exactly 8 cycles; HOLD while start=1; `run_en`=0 throughout.
- **Normal run**: start released, halt asserted on the 10th RUN cycle → `cycle_count`=10, `done`=1 the next cycle, `run_en`=0, `timeout`=0.
- **Rerun**: from DONE, start=1 → `done` falls, `cycle_count`=0, full 8-word sweep repeats, second run with halt after 3 cycles → `cycle_count`=3.
- **Watchdog** (`RUN_WATCHDOG_EN`, WDOG_LIMIT=20, halt never): `done`=1, `timeout`=1, `cycle_count`=20. Same test with halt on cycle 20 → `timeout`=0.
- **Saturation** (watchdog off, CNT_W=4, halt after 40 cycles): `cycle_count`=15 held, no wrap.
